// File: rtl/post_adder_acc_pkg.sv
// Shared constants and select encodings for the DSP48A1 post-adder/accumulator.
package dsp48_pkg;

    localparam int P_W = 48;
    localparam int M_W = 36;

    // Bit positions within the 8-bit opmode word.
    localparam int OP_X_LSB = 0;
    localparam int OP_Z_LSB = 2;
    localparam int OP_CIN   = 5;
    localparam int OP_SUB   = 7;

    typedef enum logic [1:0] {
        X_ZERO = 2'd0,
        X_M    = 2'd1,
        X_P    = 2'd2,
        X_DAB  = 2'd3
    } x_sel_e;

    typedef enum logic [1:0] {
        Z_ZERO = 2'd0,
        Z_PCIN = 2'd1,
        Z_P    = 2'd2,
        Z_C    = 2'd3
    } z_sel_e;

    localparam CARRYINSEL_OPMODE5 = "OPMODE5";
    localparam CARRYINSEL_CARRYIN = "CARRYIN";

endpackage

// File: rtl/post_adder_acc_opt_reg.sv
// Optional pipeline register: clocked with synchronous reset and CE when
// present, plain wire when bypassed.
module opt_reg #(
    parameter int W       = 1,
    parameter int PRESENT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (PRESENT != 0) begin : g_reg
            logic [W-1:0] q_r;
            always_ff @(posedge clk) begin
                if (rst)
                    q_r <= '0;
                else if (ce)
                    q_r <= d;
            end
            assign q = q_r;
        end else begin : g_bypass
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, rst, ce};
            assign q = d;
        end
    endgenerate

endmodule

// File: rtl/post_adder_acc.sv
// Post-adder/accumulator stage: X/Z operand muxes, carry-in select, 49-bit
// add/subtract and optional P/CARRYOUT registers with P feedback for MAC.
module post_adder_acc
    import dsp48_pkg::*;
#(
    parameter int PREG        = 1,
    parameter int CARRYOUTREG = 1,
    parameter int OPMODEREG   = 1,
    parameter int CARRYINREG  = 1,
    parameter     CARRYINSEL  = "OPMODE5"
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cep,
    input  logic           ceopmode,
    input  logic           cecarryin,
    input  logic [7:0]     opmode,
    input  logic [M_W-1:0] m,
    input  logic [P_W-1:0] dab,
    input  logic [P_W-1:0] c,
    input  logic [P_W-1:0] pcin,
    input  logic           carryin,
    output logic [P_W-1:0] p,
    output logic [P_W-1:0] pcout,
    output logic           carryout,
    output logic           carryoutf
);

    localparam int CIN_MODE = (CARRYINSEL == CARRYINSEL_OPMODE5) ? 1 :
                              (CARRYINSEL == CARRYINSEL_CARRYIN) ? 2 : 0;

    logic [5:0]     op_d, op_q;
    logic           cin_src, cyi;
    x_sel_e         x_sel;
    z_sel_e         z_sel;
    logic           sub;
    logic [P_W-1:0] p_q, p_fb, x_val, z_val;
    logic [P_W:0]   r;
    logic           co_q;
    logic           unused_bits;

    // Registered opmode layout: {sub, cin, z_sel, x_sel}
    assign op_d = {opmode[OP_SUB], opmode[OP_CIN], opmode[OP_Z_LSB +: 2], opmode[OP_X_LSB +: 2]};

    opt_reg #(.W(6), .PRESENT(OPMODEREG)) u_opmode_reg (
        .clk(clk), .rst(rst), .ce(ceopmode), .d(op_d), .q(op_q)
    );

    // Carry-in is sourced from the raw opmode bit so its latency is set by CYI alone.
    always_comb begin
        cin_src = 1'b0;
        if (CIN_MODE == 1)
            cin_src = opmode[OP_CIN];
        else if (CIN_MODE == 2)
            cin_src = carryin;
    end

    opt_reg #(.W(1), .PRESENT(CARRYINREG)) u_cyi_reg (
        .clk(clk), .rst(rst), .ce(cecarryin), .d(cin_src), .q(cyi)
    );

    assign x_sel = x_sel_e'(op_q[1:0]);
    assign z_sel = z_sel_e'(op_q[3:2]);
    assign sub   = op_q[5];
    assign unused_bits = ^{op_q[4], opmode[4], opmode[6]};

    generate
        if (PREG != 0) begin : g_fb
            assign p_fb = p_q;
        end else begin : g_no_fb
            assign p_fb = '0;
        end
    endgenerate

    always_comb begin
        x_val = '0;
        case (x_sel)
            X_ZERO:  x_val = '0;
            X_M:     x_val = {{(P_W-M_W){1'b0}}, m};
            X_P:     x_val = p_fb;
            X_DAB:   x_val = dab;
            default: x_val = '0;
        endcase
    end

    always_comb begin
        z_val = '0;
        case (z_sel)
            Z_ZERO:  z_val = '0;
            Z_PCIN:  z_val = pcin;
            Z_P:     z_val = p_fb;
            Z_C:     z_val = c;
            default: z_val = '0;
        endcase
    end

    // Subtraction wraps modulo 2^49, so a borrow shows up as r[48]=1.
    always_comb begin
        if (sub)
            r = {1'b0, z_val} - ({1'b0, x_val} + (P_W+1)'(cyi));
        else
            r = {1'b0, z_val} + {1'b0, x_val} + (P_W+1)'(cyi);
    end

    opt_reg #(.W(P_W), .PRESENT(PREG)) u_p_reg (
        .clk(clk), .rst(rst), .ce(cep), .d(r[P_W-1:0]), .q(p_q)
    );

    opt_reg #(.W(1), .PRESENT(CARRYOUTREG)) u_carryout_reg (
        .clk(clk), .rst(rst), .ce(cep), .d(r[P_W]), .q(co_q)
    );

    assign p         = p_q;
    assign pcout     = p_q;
    assign carryout  = co_q;
    assign carryoutf = co_q;

endmodule

// File: tb/tb_post_adder_acc.sv
// Directed test of post_adder_acc: registered instances with both carry-in
// sources plus a fully bypassed instance.
module tb_post_adder_acc;

    logic        clk = 1'b0;
    logic        rst, cep, ceopmode, cecarryin, carryin;
    logic [7:0]  opmode;
    logic [35:0] m;
    logic [47:0] dab, c, pcin;

    logic [47:0] p_a, pcout_a, p_b, pcout_b, p_c, pcout_c;
    logic        co_a, cof_a, co_b, cof_b, co_c, cof_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    post_adder_acc dut_a (
        .clk(clk), .rst(rst), .cep(cep), .ceopmode(ceopmode), .cecarryin(cecarryin),
        .opmode(opmode), .m(m), .dab(dab), .c(c), .pcin(pcin), .carryin(carryin),
        .p(p_a), .pcout(pcout_a), .carryout(co_a), .carryoutf(cof_a)
    );

    post_adder_acc #(.CARRYINSEL("CARRYIN")) dut_b (
        .clk(clk), .rst(rst), .cep(cep), .ceopmode(ceopmode), .cecarryin(cecarryin),
        .opmode(opmode), .m(m), .dab(dab), .c(c), .pcin(pcin), .carryin(carryin),
        .p(p_b), .pcout(pcout_b), .carryout(co_b), .carryoutf(cof_b)
    );

    post_adder_acc #(.PREG(0), .CARRYOUTREG(0), .OPMODEREG(0), .CARRYINREG(0)) dut_c (
        .clk(clk), .rst(rst), .cep(cep), .ceopmode(ceopmode), .cecarryin(cecarryin),
        .opmode(opmode), .m(m), .dab(dab), .c(c), .pcin(pcin), .carryin(carryin),
        .p(p_c), .pcout(pcout_c), .carryout(co_c), .carryoutf(cof_c)
    );

    task automatic check(input string tag, input logic [48:0] obs, input logic [48:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; cep = 1'b1; ceopmode = 1'b1; cecarryin = 1'b1; carryin = 1'b1;
        opmode = 8'hFF; m = 36'h123456789; dab = 48'hABCD; c = 48'h1234; pcin = 48'h55;
        tick();
        check("rst_p_a", p_a, 0);
        check("rst_co_a", co_a, 0);
        check("rst_p_b", p_b, 0);
        check("rst_co_b", co_b, 0);

        // MAC: first post-reset cycle uses the cleared opmode
        rst = 1'b0; opmode = 8'h09; m = 36'd5; carryin = 1'b0;
        tick();
        check("first_after_rst", p_a, 0);
        tick();
        check("mac_5", p_a, 48'd5);
        m = 36'd7;
        tick();
        check("mac_12", p_a, 48'd12);
        m = 36'hF_FFFF_FFFF;
        tick();
        check("mac_big", p_a, 48'h10_0000_000B);
        check("mac_big_co", co_a, 0);

        // Mid-accumulation reset
        rst = 1'b1;
        tick();
        check("mid_rst_p", p_a, 0);
        rst = 1'b0;

        // Subtract with carry-in from opmode[5]
        opmode = 8'hAF; c = 48'd100; dab = 48'd30; carryin = 1'b0;
        tick(); tick();
        check("sub_p", p_a, 48'd69);
        check("sub_co", co_a, 0);

        // Borrow through the CARRYIN source
        opmode = 8'h8C; c = 48'd0; carryin = 1'b1;
        tick(); tick();
        check("borrow_p_b", p_b, 48'hFFFF_FFFF_FFFF);
        check("borrow_co_b", co_b, 1);
        check("borrow_p_a", p_a, 0);
        check("borrow_co_a", co_a, 0);

        // Add overflow: pcin + dab
        opmode = 8'h07; pcin = 48'hFFFF_FFFF_FFFF; dab = 48'd1; carryin = 1'b0;
        tick(); tick();
        check("ovf_p", p_a, 0);
        check("ovf_co", co_a, 1);
        check("ovf_pcout", pcout_a, 0);
        check("ovf_cof", cof_a, 1);

        // Accumulate once, then freeze with cep=0 while opmode reg keeps loading
        opmode = 8'h09; m = 36'd3;
        tick(); tick();
        check("pre_hold_p", p_a, 48'd3);
        cep = 1'b0; opmode = 8'h0C; c = 48'd50;
        for (int i = 1; i <= 3; i++) begin
            m = 36'(100 * i);
            tick();
            check("hold_p", p_a, 48'd3);
            check("hold_co", co_a, 0);
        end
        cep = 1'b1;
        tick();
        check("resume_opmode_loaded", p_a, 48'd50);

        ceopmode = 1'b0; opmode = 8'h09; m = 36'd1; c = 48'd60;
        tick();
        check("ceopmode_hold", p_a, 48'd60);

        // Reset beats cep=0
        rst = 1'b1; cep = 1'b0;
        tick();
        check("rst_over_cep_p", p_a, 0);
        check("rst_over_cep_co", co_a, 0);
        rst = 1'b0; cep = 1'b1; ceopmode = 1'b1;

        // Fully bypassed instance: same-cycle combinational result
        opmode = 8'h2E; c = 48'd10;
        #1;
        check("byp_xp_p", p_c, 48'd11);
        check("byp_xp_pcout", pcout_c, 48'd11);
        opmode = 8'h0F; dab = 48'd5;
        #1;
        check("byp_add_p", p_c, 48'd15);
        opmode = 8'hAF; c = 48'd100; dab = 48'd30;
        #1;
        check("byp_sub_p", p_c, 48'd69);
        check("byp_sub_co", co_c, 0);
        opmode = 8'hAC; c = 48'd0;
        #1;
        check("byp_borrow_p", p_c, 48'hFFFF_FFFF_FFFF);
        check("byp_borrow_cof", cof_c, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
